ps2_host: RTL and testbench

Parametrised bidirectional PS/2 host port, replacing the receive-only decoder. Adds:
- a clock glitch filter of configurable length;
- a receive FIFO, with framing-error, parity-error and overflow reporting;
- a watchdog timeout on stalled frames;
- host-to-device transmit (LED and typematic commands).

It sits between the keyboard/mouse pins and the machine keyboard matrix logic. All sequential logic advances only on `ce`.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_fifo.sv | 49 ++++
 rtl/ps2_host.sv | 243 ++++++++++++++++++++++++
 tb/tb_ps2_host.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host port.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        TX_INH,
        TX_REQ,
        TX_BIT,
        TX_ACK,
        TX_END
    } state_t;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// First-word-fall-through receive FIFO; a pop frees room for a same-tick push.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else if (ce) begin
            if (do_pop)
                rp <= rp + 1'b1;
            if (do_push)
                wp <= wp + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (ce && do_push)
            mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_host.sv
// Bidirectional PS/2 host: clock filter, rx FIFO, watchdog, host-to-device tx.
// Define PS2_SCANCODE_FLAGS_EN to fold E0/F0 prefixes into rxExt/rxRel.
module ps2_host
    import ps2_pkg::*;
#(
    parameter int FILTER     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096,
    parameter int INHIBIT    = 1600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    inout  wire        ps2Ck,
    inout  wire        ps2DQ,
    output logic       rxValid,
    output logic [7:0] rxData,
    input  logic       rxRead,
    output logic       rxError,
    output logic       rxOverflow,
`ifdef PS2_SCANCODE_FLAGS_EN
    output logic       rxExt,
    output logic       rxRel,
`endif
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       txDone,
    output logic       txError
);

`ifdef PS2_SCANCODE_FLAGS_EN
    localparam int W = 10;
`else
    localparam int W = 8;
`endif
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(INHIBIT + 1);

    logic [FILTER-1:0] filt;
    logic              ckf;
    logic              fall;
    logic              dqr;

    state_t            state;
    logic              ck_oe;
    logic              dq_oe;
    logic [3:0]        bitcnt;
    logic [9:0]        rxsh;
    logic [8:0]        txsh;
    logic              chk;
    logic [TW-1:0]     tmo;
    logic [IW-1:0]     inh;

    logic              good;
    logic              push;
    logic              full;
    logic              empty;
    logic [W-1:0]      wdata;
    logic [W-1:0]      rdata;

    assign ps2Ck = ck_oe ? 1'b0 : 1'bz;
    assign ps2DQ = dq_oe ? 1'b0 : 1'bz;

    // rxsh holds {stop, parity, data} once the frame is complete
    assign good = chk && (^rxsh[8:0]) && rxsh[9];

`ifdef PS2_SCANCODE_FLAGS_EN
    logic ext;
    logic rel;
    assign push  = good && (rxsh[7:0] != PS2_EXT) &&
                   (rxsh[7:0] != PS2_REL);
    assign wdata = {rel, ext, rxsh[7:0]};
    assign rxExt = rdata[8];
    assign rxRel = rdata[9];
`else
    assign push  = good;
    assign wdata = rxsh[7:0];
`endif

    assign rxData  = rdata[7:0];
    assign rxValid = !empty;
    assign txReady = (state == IDLE);

    ps2_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .push  (push),
        .wdata (wdata),
        .pop   (rxRead),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt <= '1;
            ckf  <= 1'b1;
            fall <= 1'b0;
            dqr  <= 1'b1;
        end else if (ce) begin
            filt <= {filt[FILTER-2:0], ps2Ck};
            dqr  <= ps2DQ;
            fall <= 1'b0;
            if (&filt) begin
                ckf <= 1'b1;
            end else if (~|filt) begin
                ckf  <= 1'b0;
                fall <= ckf;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ck_oe      <= 1'b0;
            dq_oe      <= 1'b0;
            bitcnt     <= '0;
            rxsh       <= '0;
            txsh       <= '0;
            chk        <= 1'b0;
            tmo        <= '0;
            inh        <= '0;
            rxError    <= 1'b0;
            rxOverflow <= 1'b0;
            txDone     <= 1'b0;
            txError    <= 1'b0;
`ifdef PS2_SCANCODE_FLAGS_EN
            ext        <= 1'b0;
            rel        <= 1'b0;
`endif
        end else if (ce) begin
            chk        <= 1'b0;
            rxError    <= chk && !good;
            rxOverflow <= push && full && !rxRead;
            txDone     <= 1'b0;
            txError    <= 1'b0;
`ifdef PS2_SCANCODE_FLAGS_EN
            if (good) begin
                if (rxsh[7:0] == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (rxsh[7:0] == PS2_REL) begin
                    rel <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    rel <= 1'b0;
                end
            end else if (chk) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end
`endif
            if (state == IDLE || fall)
                tmo <= '0;
            else
                tmo <= tmo + 1'b1;

            if (state != IDLE && !fall &&
                tmo == TW'(TIMEOUT - 1)) begin
                state <= IDLE;
                ck_oe <= 1'b0;
                dq_oe <= 1'b0;
                if (state == RX) begin
                    rxError <= 1'b1;
`ifdef PS2_SCANCODE_FLAGS_EN
                    ext     <= 1'b0;
                    rel     <= 1'b0;
`endif
                end else begin
                    txError <= 1'b1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (txValid) begin
                            state <= TX_INH;
                            txsh  <= {odd_parity(txData), txData};
                            ck_oe <= 1'b1;
                            inh   <= '0;
                        end else if (fall && !dqr) begin
                            state  <= RX;
                            bitcnt <= '0;
                        end
                    end
                    RX: begin
                        if (fall) begin
                            rxsh   <= {dqr, rxsh[9:1]};
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == 4'(FRAME_LEN - 2)) begin
                                state <= IDLE;
                                chk   <= 1'b1;
                            end
                        end
                    end
                    TX_INH: begin
                        if (inh == IW'(INHIBIT - 1)) begin
                            state <= TX_REQ;
                            ck_oe <= 1'b0;
                            dq_oe <= 1'b1;
                        end else begin
                            inh <= inh + 1'b1;
                        end
                    end
                    TX_REQ: begin
                        bitcnt <= '0;
                        state  <= TX_BIT;
                    end
                    TX_BIT: begin
                        if (fall) begin
                            if (bitcnt == 4'd9) begin
                                dq_oe <= 1'b0;
                                state <= TX_ACK;
                            end else begin
                                dq_oe  <= ~txsh[0];
                                txsh   <= {1'b0, txsh[8:1]};
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (fall) begin
                            txDone  <= !dqr;
                            txError <= dqr;
                            state   <= TX_END;
                        end
                    end
                    TX_END: begin
                        if (ckf)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host with a behavioural PS/2 device on the pins.
module tb_ps2_host;

    localparam int FILT  = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int INH   = 40;
    localparam int HALF  = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic       rxRead = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       rxValid;
    logic [7:0] rxData;
    logic       rxError;
    logic       rxOverflow;
    logic       txReady;
    logic       txDone;
    logic       txError;
`ifdef PS2_SCANCODE_FLAGS_EN
    logic       rxExt;
    logic       rxRel;
`endif

    wire  ck;
    wire  dq;
    logic dev_ck = 1'b1;
    logic dev_dq = 1'b1;

    pullup (ck);
    pullup (dq);
    assign ck = dev_ck ? 1'bz : 1'b0;
    assign dq = dev_dq ? 1'bz : 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int n_rxerr  = 0;
    int n_ovf    = 0;
    int n_done   = 0;
    int n_txerr  = 0;
    logic q_re = 1'b0;
    logic q_ov = 1'b0;
    logic q_td = 1'b0;
    logic q_te = 1'b0;

    ps2_host #(
        .FILTER     (FILT),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .INHIBIT    (INH)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .ce         (ce),
        .ps2Ck      (ck),
        .ps2DQ      (dq),
        .rxValid    (rxValid),
        .rxData     (rxData),
        .rxRead     (rxRead),
        .rxError    (rxError),
        .rxOverflow (rxOverflow),
`ifdef PS2_SCANCODE_FLAGS_EN
        .rxExt      (rxExt),
        .rxRel      (rxRel),
`endif
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .txDone     (txDone),
        .txError    (txError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ce <= ~ce;

    always @(negedge clk) begin
        if (rxError && !q_re)    n_rxerr++;
        if (rxOverflow && !q_ov) n_ovf++;
        if (txDone && !q_td)     n_done++;
        if (txError && !q_te)    n_txerr++;
        q_re = rxError;
        q_ov = rxOverflow;
        q_td = txDone;
        q_te = txError;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_ce;
        @(negedge clk);
        while (!ce) @(negedge clk);
    endtask

    task automatic dev_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            dev_dq = f[i];
            wait_clk(HALF);
            dev_ck = 1'b0;
            wait_clk(HALF);
            dev_ck = 1'b1;
        end
        dev_dq = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        dev_bits({1'b1, p, b, 1'b0}, 11);
    endtask

    function automatic logic par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic read_pulse;
        align_ce();
        rxRead = 1'b1;
        @(negedge clk);
        rxRead = 1'b0;
    endtask

    task automatic do_tx(input  logic [7:0] b,
                         input  logic       ack,
                         output logic [9:0] bits,
                         output int         low,
                         output logic       ok);
        ok   = 1'b0;
        low  = 0;
        bits = '0;
        align_ce();
        txData  = b;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        check("tx_busy", txReady, 0);
        for (int n = 0; n < 1000; n++) begin
            if (ck === 1'b1 && dq === 1'b0) begin
                ok = 1'b1;
                break;
            end
            if (ck === 1'b0) low++;
            @(negedge clk);
        end
        check("tx_start", ok, 1);
        wait_clk(HALF);
        for (int i = 0; i < 10; i++) begin
            dev_ck = 1'b0;
            wait_clk(HALF);
            dev_ck = 1'b1;
            bits[i] = dq;
            wait_clk(HALF);
        end
        dev_dq = ack;
        dev_ck = 1'b0;
        wait_clk(HALF);
        dev_ck = 1'b1;
        wait_clk(HALF);
        dev_dq = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    logic [7:0] exp_q [4];
    logic [9:0] bits;
    int         low;
    logic       ok;
    logic       hit;

    initial begin
        wait_clk(3);
        check("rst_rxValid", rxValid, 0);
        check("rst_rxError", rxError, 0);
        check("rst_rxOverflow", rxOverflow, 0);
        check("rst_txDone", txDone, 0);
        check("rst_txError", txError, 0);
        check("rst_ck", ck, 1);
        check("rst_dq", dq, 1);
        rst = 1'b0;
        wait_clk(4);
        check("rst_txReady", txReady, 1);

        send(8'h1C, 1'b0);
        check("rx1c_valid", rxValid, 1);
        check("rx1c_data", rxData, 8'h1C);
        check("rx1c_noerr", n_rxerr, 0);
        read_pulse();
        wait_clk(2);
        check("rx1c_popped", rxValid, 0);

        send(8'h1C, 1'b1);
        check("badpar_err", n_rxerr, 1);
        check("badpar_empty", rxValid, 0);

        for (int b = 1; b <= 5; b++)
            send(8'(b), par(8'(b)));
        check("ovf_pulse", n_ovf, 1);
        check("ovf_head", rxData, 8'h01);

        hit = 1'b0;
        fork
            send(8'h06, par(8'h06));
            begin
                for (int n = 0; n < 2000; n++) begin
                    @(negedge clk);
                    if (ce && dut.push) begin
                        hit = 1'b1;
                        break;
                    end
                end
                rxRead = hit;
                @(negedge clk);
                rxRead = 1'b0;
            end
        join
        check("ovf_poppush", hit, 1);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int i = 0; i < 4; i++) begin
            check("ovf_entry", {rxValid, rxData}, {1'b1, exp_q[i]});
            read_pulse();
            wait_clk(2);
        end
        check("ovf_drained", rxValid, 0);
        check("ovf_once", n_ovf, 1);

        dev_bits(11'h00A, 4);
        wait_clk(2 * TMO + 100);
        check("tmo_err", n_rxerr, 2);
        check("tmo_idle", txReady, 1);
        check("tmo_empty", rxValid, 0);
        send(8'h5A, 1'b1);
        check("tmo_5a_valid", rxValid, 1);
        check("tmo_5a_data", rxData, 8'h5A);
        check("tmo_5a_noerr", n_rxerr, 2);
        read_pulse();
        wait_clk(2);

        do_tx(8'hED, 1'b0, bits, low, ok);
        wait_clk(20);
        check("tx_inhibit", low, 2 * INH);
        check("tx_data", bits[7:0], 8'hED);
        check("tx_parity", bits[8], 1);
        check("tx_stop", bits[9], 1);
        check("tx_done", n_done, 1);
        check("tx_noerr", n_txerr, 0);
        check("tx_ready", txReady, 1);
        check("tx_no_rx", {n_rxerr[7:0], rxValid}, {8'd2, 1'b0});

        do_tx(8'hED, 1'b1, bits, low, ok);
        wait_clk(20);
        check("txnak_err", n_txerr, 1);
        check("txnak_done", n_done, 1);
        check("txnak_ready", txReady, 1);

`ifdef PS2_SCANCODE_FLAGS_EN
        send(8'hE0, par(8'hE0));
        send(8'hF0, par(8'hF0));
        send(8'h74, par(8'h74));
        check("flag_74", {rxValid, rxRel, rxExt, rxData},
              {1'b1, 1'b1, 1'b1, 8'h74});
        read_pulse();
        wait_clk(2);
        check("flag_single", rxValid, 0);
        send(8'h1C, 1'b0);
        check("flag_1c", {rxValid, rxRel, rxExt, rxData},
              {1'b1, 1'b0, 1'b0, 8'h1C});
        read_pulse();
        wait_clk(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
